// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time (rise to fall) of an
// asynchronous PWM input in Clk50M cycles, with a static-level timeout.
module pwm_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic        Clk50M,
  input  logic        Rst,
  input  logic        cap_en,
  input  logic        pwm_in,
  output logic [31:0] meas_period,
  output logic [31:0] meas_high,
  output logic        meas_valid,
  output logic        timeout,
  output logic        pwm_level
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [31:0]            cnt;
  logic [31:0]            high_lat;

  // Counter stops at all-ones instead of wrapping back to a small, plausible value.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Synchronizer and edge-detect stage
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= s;
    end
  end

  assign s         = sync[SYNC_STAGES-1];
  assign rise      = s & ~s_d;
  assign fall      = ~s & s_d;
  assign pwm_level = s;

  // Measurement FSM; edges are tested before the timeout so an edge always wins
  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      high_lat    <= '0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!cap_en) begin
        state   <= IDLE;
        cnt     <= '0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state   <= HIGH;
              cnt     <= 32'd1;
              timeout <= 1'b0;
            end
          end
          HIGH: begin
            if (fall) begin
              state    <= LOW;
              high_lat <= cnt;
              cnt      <= sat_inc(cnt);
            end else if (cnt == TIMEOUT_CYC) begin
              state   <= IDLE;
              cnt     <= '0;
              timeout <= 1'b1;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          LOW: begin
            if (rise) begin
              state       <= HIGH;
              meas_period <= cnt;
              meas_high   <= high_lat;
              meas_valid  <= 1'b1;
              cnt         <= 32'd1;
            end else if (cnt == TIMEOUT_CYC) begin
              state   <= IDLE;
              cnt     <= '0;
              timeout <= 1'b1;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
